// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types and constants for the binary/BCD converters
// Contents:
//   bcd_digit_t    one packed BCD digit
//   BCD_MAX_DIGIT  largest legal digit value
//   b2b_state_t    converter FSM states
//   bcd_digit_bad  flags a digit outside 0..9
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } b2b_state_t;

    function automatic logic bcd_digit_bad(input bcd_digit_t d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// rtl/bcd_digit_sub3.sv - per-digit correction step of reverse double-dabble
// Ports:
//   d_in   digit after the right shift
//   d_out  d_in-3 when d_in>=8, else d_in unchanged
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  bcd_digit_t d_in,
    output bcd_digit_t d_out
);

    // A digit >=8 after the shift received a carried-in 8 that is really a
    // decimal 5 (half of 10), so 3 is taken off. Never underflows.
    assign d_out = (d_in >= 4'd8) ? (d_in - 4'd3) : d_in;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential 4-digit BCD to binary converter, one bit per clock
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      conversion request, honoured in IDLE or DONE only
//   bcd3..bcd0 thousands..units digits, captured on the accept edge
//   bin_out    binary result, valid while done
//   busy       high while converting
//   done       level, high from completion until next accepted start or rst
//   err_digit  some digit was >9, valid while done
//   overflow   value did not fit OUT_WIDTH bits, valid while done
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int OUT_WIDTH = 14,
    parameter int DIGITS    = 4     // ports carry exactly four digits
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           bcd3,
    input  logic [3:0]           bcd2,
    input  logic [3:0]           bcd1,
    input  logic [3:0]           bcd0,
    output logic [OUT_WIDTH-1:0] bin_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err_digit,
    output logic                 overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + OUT_WIDTH;
    localparam int CNT_W = $clog2(OUT_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_WIDTH - 1);

    b2b_state_t           state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] bin_out_q, bin_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_digit_q, err_digit_d;
    logic                 overflow_q, overflow_d;

    logic [SR_W-1:0]      sr_shift;
    logic [SR_W-1:0]      sr_corr;
    logic                 any_bad;

    // Upper field holds the shrinking BCD value, lower field collects the
    // binary bits LSB-first from the top down.
    assign sr_shift = sr_q >> 1;
    assign sr_corr[OUT_WIDTH-1:0] = sr_shift[OUT_WIDTH-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .d_in  (sr_shift[OUT_WIDTH + 4*g +: 4]),
            .d_out (sr_corr[OUT_WIDTH + 4*g +: 4])
        );
    end

    assign any_bad = bcd_digit_bad(bcd3) | bcd_digit_bad(bcd2) |
                     bcd_digit_bad(bcd1) | bcd_digit_bad(bcd0);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        bin_out_d   = bin_out_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_digit_d = err_digit_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (any_bad) begin
                        // Rejected immediately; no iterations are run.
                        state_d     = DONE;
                        bin_out_d   = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        err_digit_d = 1'b1;
                        overflow_d  = 1'b0;
                    end else begin
                        // bin_out keeps the previous result until completion.
                        state_d     = CONV;
                        sr_d        = {bcd3, bcd2, bcd1, bcd0, {OUT_WIDTH{1'b0}}};
                        cnt_d       = '0;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                        err_digit_d = 1'b0;
                        overflow_d  = 1'b0;
                    end
                end
            end
            CONV: begin
                sr_d  = sr_corr;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Any residue left in the BCD field is value >> OUT_WIDTH.
                    state_d    = DONE;
                    bin_out_d  = sr_shift[OUT_WIDTH-1:0];
                    overflow_d = |sr_shift[SR_W-1:OUT_WIDTH];
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            bin_out_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_digit_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            bin_out_q   <= bin_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_digit_q <= err_digit_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_digit = err_digit_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - self-checking bench for bcd_to_bin at 14 and 11 output bits
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;

    logic [13:0] bin14;
    logic        busy14, done14, err14, ovf14;
    logic [10:0] bin11;
    logic        busy11, done11, err11, ovf11;

    always #5 clk = ~clk;

    bcd_to_bin u_dut14 (
        .clk(clk), .rst(rst), .start(start),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .bin_out(bin14), .busy(busy14), .done(done14),
        .err_digit(err14), .overflow(ovf14)
    );

    bcd_to_bin #(.OUT_WIDTH(11)) u_dut11 (
        .clk(clk), .rst(rst), .start(start),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .bin_out(bin11), .busy(busy11), .done(done11),
        .err_digit(err11), .overflow(ovf11)
    );

    typedef struct {
        logic [13:0] bin;
        logic        err;
        logic        ovf;
        int          lat;
        int          busy_cycles;
    } exp_t;

    exp_t        q14[$];
    exp_t        q11[$];
    int          total = 0;
    int          bad   = 0;
    logic [13:0] last14;
    logic [10:0] last11;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] d3, input logic [3:0] d2,
                                   input logic [3:0] d1, input logic [3:0] d0, input int w);
        exp_t e;
        int   v;
        if (d3 > 4'd9 || d2 > 4'd9 || d1 > 4'd9 || d0 > 4'd9) begin
            e.bin = '0; e.err = 1'b1; e.ovf = 1'b0; e.lat = 1; e.busy_cycles = 0;
        end else begin
            v = int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0);
            e.bin = 14'(v % (1 << w));
            e.err = 1'b0;
            e.ovf = (v >= (1 << w));
            e.lat = w + 1;
            e.busy_cycles = w;
        end
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ":bin14"},  32'(bin14),  32'd0);
        check({tag, ":busy14"}, 32'(busy14), 32'd0);
        check({tag, ":done14"}, 32'(done14), 32'd0);
        check({tag, ":err14"},  32'(err14),  32'd0);
        check({tag, ":ovf14"},  32'(ovf14),  32'd0);
        check({tag, ":bin11"},  32'(bin11),  32'd0);
        check({tag, ":busy11"}, 32'(busy11), 32'd0);
        check({tag, ":done11"}, 32'(done11), 32'd0);
        check({tag, ":err11"},  32'(err11),  32'd0);
        check({tag, ":ovf11"},  32'(ovf11),  32'd0);
    endtask

    // Edge 1 is the accept edge; completion is the first sample with done=1.
    task automatic convert(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input int restart_at, input string tag);
        exp_t e14, e11;
        int   busy_cnt14, busy_cnt11;
        bit   got14, got11, is_err;
        @(negedge clk);
        bcd3 = a; bcd2 = b; bcd1 = c; bcd0 = d;
        start = 1'b1;
        q14.push_back(model(a, b, c, d, 14));
        q11.push_back(model(a, b, c, d, 11));
        is_err = q14[$].err;
        busy_cnt14 = 0; busy_cnt11 = 0;
        got14 = 1'b0; got11 = 1'b0;
        for (int e = 1; e <= 40 && !(got14 && got11); e++) begin
            @(negedge clk);
            if (e == 1) begin
                start = 1'b0;
                bcd3 = 4'd7; bcd2 = 4'd7; bcd1 = 4'd7; bcd0 = 4'd7;
                if (!is_err) begin
                    check({tag, ":hold14"}, 32'(bin14), 32'(last14));
                    check({tag, ":hold11"}, 32'(bin11), 32'(last11));
                end
            end
            if (restart_at != 0 && e == restart_at) begin
                bcd3 = 4'd9; bcd2 = 4'd8; bcd1 = 4'd7; bcd0 = 4'd6;
                start = 1'b1;
            end
            if (restart_at != 0 && e == restart_at + 1) start = 1'b0;
            if (busy14) busy_cnt14++;
            if (busy11) busy_cnt11++;
            if (!got14 && done14) begin
                got14 = 1'b1;
                e14 = q14.pop_front();
                check({tag, ":lat14"},  32'(e),          32'(e14.lat));
                check({tag, ":bin14"},  32'(bin14),      32'(e14.bin));
                check({tag, ":err14"},  32'(err14),      32'(e14.err));
                check({tag, ":ovf14"},  32'(ovf14),      32'(e14.ovf));
                check({tag, ":nbusy14"}, 32'(busy_cnt14), 32'(e14.busy_cycles));
                last14 = e14.bin;
            end
            if (!got11 && done11) begin
                got11 = 1'b1;
                e11 = q11.pop_front();
                check({tag, ":lat11"},  32'(e),          32'(e11.lat));
                check({tag, ":bin11"},  32'(bin11),      32'(e11.bin[10:0]));
                check({tag, ":err11"},  32'(err11),      32'(e11.err));
                check({tag, ":ovf11"},  32'(ovf11),      32'(e11.ovf));
                check({tag, ":nbusy11"}, 32'(busy_cnt11), 32'(e11.busy_cycles));
                last11 = e11.bin[10:0];
            end
        end
        check({tag, ":completed14"}, 32'(got14), 32'd1);
        check({tag, ":completed11"}, 32'(got11), 32'd1);
        q14.delete();
        q11.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
        last14 = '0; last11 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        convert(4'd1, 4'd2, 4'd3, 4'd4, 0, "d1234");
        convert(4'd9, 4'd9, 4'd9, 4'd9, 0, "d9999");
        convert(4'd0, 4'd0, 4'd0, 4'd0, 0, "d0000");
        convert(4'd1, 4'd2, 4'hA, 4'd3, 0, "baddigit");
        convert(4'd2, 4'd0, 4'd4, 4'd8, 0, "d2048");
        convert(4'd2, 4'd0, 4'd4, 4'd7, 0, "d2047");
        convert(4'd1, 4'd2, 4'd3, 4'd4, 5, "restart_ignored");

        // Reset in the middle of a conversion.
        @(negedge clk);
        bcd3 = 4'd5; bcd2 = 4'd6; bcd1 = 4'd7; bcd0 = 4'd8;
        start = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (e == 1) start = 1'b0;
        end
        check({"midrst", ":busy14_before"}, 32'(busy14), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        last14 = '0; last11 = '0;

        convert(4'd0, 4'd0, 4'd4, 4'd2, 0, "d0042");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
